// File: rtl/gripper_actuator_ctrl.sv
// N-channel pump/valve actuator controller: PID sign/magnitude -> inflate (PWM pump), hold, vent (valve).
// Latency: pid_in/start changes reach pump_out/valve_out two CLK edges later (state reg, then output reg).
// Backpressure: none; outputs drive pins directly, and reversals are gated by a dead-time interlock.
//
// Ports:
//   CLK, resetn (sync, active-low), start (level enable), pwm_tick (PWM strobe),
//   pid_in (NUM_CH packed signed PID words), pump_out/valve_out (per-channel drives),
//   state_out (3-bit state code per channel), fault (latched over-inflate trip).
// Optional build macro: GRIP_SOFTSTART_EN -- INFLATE entry starts duty at 0 and ramps +1 per PWM period.
module gripper_actuator_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int PID_W       = 16,
    parameter int PWM_BITS    = 8,
    parameter int DUTY_SHIFT  = 7,
    parameter int DEADBAND    = 64,
    parameter int DEAD_TIME   = 100,
    parameter int MAX_INFLATE = 200
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      pwm_tick,
    input  logic [NUM_CH*PID_W-1:0]   pid_in,
    output logic [NUM_CH-1:0]         pump_out,
    output logic [NUM_CH-1:0]         valve_out,
    output logic [3*NUM_CH-1:0]       state_out,
    output logic [NUM_CH-1:0]         fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_INFLATE = 3'd2,
        S_VENT    = 3'd3,
        S_DEAD    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam int DT_W = $clog2(DEAD_TIME + 1);
    localparam int IC_W = $clog2(MAX_INFLATE + 1);

    localparam logic [PWM_BITS-1:0]     PWM_MAX   = '1;
    localparam logic [PID_W:0]          PWM_MAX_X = {{(PID_W + 1 - PWM_BITS){1'b0}}, PWM_MAX};
    localparam logic signed [PID_W-1:0] DB_POS    = PID_W'(DEADBAND);
    localparam logic signed [PID_W-1:0] DB_NEG    = -DB_POS;
    localparam logic [DT_W-1:0]         DT_LAST   = DT_W'(DEAD_TIME - 1);
    localparam logic [IC_W-1:0]         IC_MAX    = IC_W'(MAX_INFLATE);

    // Shared PWM counter; every channel compares against the same phase.
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_wrap;

    assign w_wrap = pwm_tick && (r_cnt == PWM_MAX);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (pwm_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [PID_W-1:0] w_pid;
        logic [PID_W:0]          w_pid_ext;
        logic [PID_W:0]          w_mag;
        logic [PID_W:0]          w_shift;
        logic [PWM_BITS-1:0]     w_target;
        logic [PWM_BITS-1:0]     w_entry_duty;
        logic                    w_hi;
        logic                    w_lo;

        state_t              r_state;
        state_t              r_target;
        logic [DT_W-1:0]     r_dead;
        logic [IC_W-1:0]     r_icnt;
        logic [PWM_BITS-1:0] r_duty;
        logic                r_pump;
        logic                r_valve;
        logic                r_fault;

        assign w_pid     = pid_in[k*PID_W +: PID_W];
        // One extra bit so the most negative input has a representable magnitude.
        assign w_pid_ext = {w_pid[PID_W-1], w_pid};
        assign w_mag     = w_pid[PID_W-1] ? (~w_pid_ext + 1'b1) : w_pid_ext;
        assign w_shift   = w_mag >> DUTY_SHIFT;
        assign w_target  = (w_shift > PWM_MAX_X) ? PWM_MAX : w_shift[PWM_BITS-1:0];
        assign w_hi      = w_pid > DB_POS;
        assign w_lo      = w_pid < DB_NEG;

`ifdef GRIP_SOFTSTART_EN
        assign w_entry_duty = '0;
`else
        assign w_entry_duty = w_target;
`endif

        always_ff @(posedge CLK) begin
            if (!resetn) begin
                r_state  <= S_IDLE;
                r_target <= S_IDLE;
                r_dead   <= '0;
                r_icnt   <= '0;
                r_duty   <= '0;
                r_pump   <= 1'b0;
                r_valve  <= 1'b0;
                r_fault  <= 1'b0;
            end else begin
                // Outputs follow the registered state one edge later; only one can be set.
                r_pump  <= (r_state == S_INFLATE) && (r_cnt < r_duty);
                r_valve <= (r_state == S_VENT);

                // Duty only moves at the period boundary so a PWM period is never cut short.
                if (w_wrap) begin
`ifdef GRIP_SOFTSTART_EN
                    if (w_target < r_duty) begin
                        r_duty <= w_target;
                    end else if (w_target > r_duty) begin
                        r_duty <= r_duty + 1'b1;
                    end
`else
                    r_duty <= w_target;
`endif
                end

                if (!start) begin
                    r_state <= S_IDLE;
                    r_fault <= 1'b0;
                    r_icnt  <= '0;
                    r_dead  <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: r_state <= S_HOLD;
                        S_HOLD: begin
                            if (w_hi) begin
                                r_state <= S_INFLATE;
                                r_duty  <= w_entry_duty;
                            end else if (w_lo) begin
                                r_state <= S_VENT;
                            end
                        end
                        S_INFLATE: begin
                            if (r_icnt == IC_MAX) begin
                                r_state <= S_FAULT;
                                r_fault <= 1'b1;
                                r_icnt  <= '0;
                            end else if (w_lo) begin
                                r_state  <= S_DEAD;
                                r_target <= S_VENT;
                                r_dead   <= '0;
                                r_icnt   <= '0;
                            end else if (!w_hi) begin
                                r_state <= S_HOLD;
                                r_icnt  <= '0;
                            end else if (w_wrap) begin
                                r_icnt <= r_icnt + 1'b1;
                            end
                        end
                        S_VENT: begin
                            if (w_hi) begin
                                r_state  <= S_DEAD;
                                r_target <= S_INFLATE;
                                r_dead   <= '0;
                            end else if (!w_lo) begin
                                r_state <= S_HOLD;
                            end
                        end
                        S_DEAD: begin
                            // Inputs are ignored until expiry; the target only wins if still demanded.
                            if (r_dead == DT_LAST) begin
                                if ((r_target == S_INFLATE) && w_hi) begin
                                    r_state <= S_INFLATE;
                                    r_duty  <= w_entry_duty;
                                end else if ((r_target == S_VENT) && w_lo) begin
                                    r_state <= S_VENT;
                                end else begin
                                    r_state <= S_HOLD;
                                end
                            end else begin
                                r_dead <= r_dead + 1'b1;
                            end
                        end
                        S_FAULT: r_state <= S_FAULT;
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end

        assign pump_out[k]       = r_pump;
        assign valve_out[k]      = r_valve;
        assign state_out[3*k +: 3] = r_state;
        assign fault[k]          = r_fault;
    end

endmodule
